memory_bist: RTL and testbench

Built-in self-test controller that sits directly upstream of `memory` and owns its `wr`/`rd`/`addr`/`data` pins during test. On `start` it walks every address downward writing a deterministic pattern, then walks again reading and comparing. It reports pass/fail, plus the first failing address and the data read there, to the system-level test sequencer.

---
 rtl/memory_bist_pkg.sv | 30 +++
 rtl/memory_bist_addr_gen.sv | 41 ++++
 rtl/memory_bist.sv | 225 ++++++++++++++++++++++
 tb/tb_memory_bist.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_bist_pkg.sv
// Shared definitions for the memory BIST controller: FSM state encoding and
// the deterministic test pattern function.
package memory_bist_pkg;

    // Controller states. WRITE_INV/READ_INV are only reachable when the
    // MEMORY_BIST_INVERT_PASS_EN build option is defined.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WRITE     = 3'd1,
        ST_TURN      = 3'd2,
        ST_READ      = 3'd3,
        ST_DONE      = 3'd4,
        ST_WRITE_INV = 3'd5,
        ST_READ_INV  = 3'd6
    } state_t;

    // Pattern for address a in a memory with 2^awidth locations: (N-1-a),
    // optionally inverted. Computed at 64 bits so the caller's truncation to
    // the data width gives both zero-extension and full-width inversion.
    function automatic logic [63:0] pattern(input logic [63:0] a,
                                            input int          awidth,
                                            input logic        inv);
        logic [63:0] top_addr;
        logic [63:0] p;
        top_addr = (awidth >= 64) ? {64{1'b1}} : ((64'd1 << awidth) - 64'd1);
        p        = top_addr - a;
        return inv ? ~p : p;
    endfunction

endpackage

// File: rtl/memory_bist_addr_gen.sv
// Address down-counter for the BIST walk: synchronous load of all-ones,
// decrement on enable, and a flag marking the final address (0).
module memory_bist_addr_gen #(
    parameter int AWIDTH = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              en,
    output logic [AWIDTH-1:0] count,
    output logic [AWIDTH-1:0] count_next,
    output logic              last
);

    logic [AWIDTH-1:0] count_q;
    logic [AWIDTH-1:0] count_d;

    // Load wins over decrement; the counter never wraps on its own.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = '1;
        end else if (en) begin
            count_d = count_q - AWIDTH'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count      = count_q;
    assign count_next = count_d;
    assign last       = (count_q == '0);

endmodule

// File: rtl/memory_bist.sv
// Memory BIST controller: writes P(a) to every address walking downward,
// then reads back and compares, reporting pass/fail and the first failing
// address and data. Build option MEMORY_BIST_INVERT_PASS_EN adds a second
// write/read pass using the inverted pattern ~P(a).
module memory_bist
    import memory_bist_pkg::*;
#(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              wr,
    output logic              rd,
    output logic [AWIDTH-1:0] addr,
    inout  wire  [DWIDTH-1:0] data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [AWIDTH-1:0] fail_addr,
    output logic [DWIDTH-1:0] fail_data
);

    state_t            state_q, state_d;
    logic              wr_q, wr_d;
    logic              rd_q, rd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [AWIDTH-1:0] fail_addr_q, fail_addr_d;
    logic [DWIDTH-1:0] fail_data_q, fail_data_d;
    logic [DWIDTH-1:0] pat_q, pat_d;

    logic              addr_load;
    logic              addr_en;
    logic              addr_last;
    logic [AWIDTH-1:0] addr_q;
    logic [AWIDTH-1:0] addr_next;
    logic              inv_d;
    logic              mismatch;

`ifdef MEMORY_BIST_INVERT_PASS_EN
    // TURN is shared by three transitions, so remember where it leads.
    state_t            turn_to_q, turn_to_d;
`else
    state_t            turn_to_q;
    assign turn_to_q = ST_READ;
`endif

    memory_bist_addr_gen #(
        .AWIDTH (AWIDTH)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .load       (addr_load),
        .en         (addr_en),
        .count      (addr_q),
        .count_next (addr_next),
        .last       (addr_last)
    );

`ifdef MEMORY_BIST_INVERT_PASS_EN
    assign inv_d = (state_d == ST_WRITE_INV) || (state_d == ST_READ_INV);
`else
    assign inv_d = 1'b0;
`endif

    // The pattern register tracks the address register so the expected
    // value for the current address is ready without a combinational path.
    assign pat_d    = DWIDTH'(pattern(64'(addr_next), AWIDTH, inv_d));
    assign mismatch = (data != pat_q);

    // Next-state and next-output logic for the test sequence.
    always_comb begin
        state_d     = state_q;
        wr_d        = 1'b0;
        rd_d        = 1'b0;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        addr_load   = 1'b0;
        addr_en     = 1'b0;
`ifdef MEMORY_BIST_INVERT_PASS_EN
        turn_to_d   = turn_to_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_WRITE;
                    addr_load   = 1'b1;
                    wr_d        = 1'b1;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_data_d = '0;
                end
            end
            ST_WRITE: begin
                if (addr_last) begin
                    state_d   = ST_TURN;
`ifdef MEMORY_BIST_INVERT_PASS_EN
                    turn_to_d = ST_READ;
`endif
                end else begin
                    wr_d    = 1'b1;
                    addr_en = 1'b1;
                end
            end
            ST_TURN: begin
                addr_load = 1'b1;
                state_d   = turn_to_q;
`ifdef MEMORY_BIST_INVERT_PASS_EN
                if (turn_to_q == ST_WRITE_INV) begin
                    wr_d = 1'b1;
                end else begin
                    rd_d = 1'b1;
                end
`else
                rd_d = 1'b1;
`endif
            end
            ST_READ: begin
                if (mismatch) begin
                    state_d     = ST_DONE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    pass_d      = 1'b0;
                    fail_addr_d = addr_q;
                    fail_data_d = data;
                end else if (addr_last) begin
`ifdef MEMORY_BIST_INVERT_PASS_EN
                    state_d   = ST_TURN;
                    turn_to_d = ST_WRITE_INV;
`else
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = 1'b1;
`endif
                end else begin
                    rd_d    = 1'b1;
                    addr_en = 1'b1;
                end
            end
`ifdef MEMORY_BIST_INVERT_PASS_EN
            ST_WRITE_INV: begin
                if (addr_last) begin
                    state_d   = ST_TURN;
                    turn_to_d = ST_READ_INV;
                end else begin
                    wr_d    = 1'b1;
                    addr_en = 1'b1;
                end
            end
            ST_READ_INV: begin
                if (mismatch) begin
                    state_d     = ST_DONE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    pass_d      = 1'b0;
                    fail_addr_d = addr_q;
                    fail_data_d = data;
                end else if (addr_last) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = 1'b1;
                end else begin
                    rd_d    = 1'b1;
                    addr_en = 1'b1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops the strobes on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            pat_q       <= '0;
`ifdef MEMORY_BIST_INVERT_PASS_EN
            turn_to_q   <= ST_READ;
`endif
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            pat_q       <= pat_d;
`ifdef MEMORY_BIST_INVERT_PASS_EN
            turn_to_q   <= turn_to_d;
`endif
        end
    end

    assign wr        = wr_q;
    assign rd        = rd_q;
    assign addr      = addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;
    assign data      = wr_q ? pat_q : {DWIDTH{1'bz}};

endmodule

// File: tb/tb_memory_bist.sv
// Testbench for memory_bist: behavioural memory with selectable faults, a
// write scoreboard fed when each run is launched, and per-scenario tasks.
module tb_memory_bist;

`ifdef MEMORY_BIST_INVERT_PASS_EN
    localparam int CLEAN_EDGE   = 131;
    localparam int CLEAN_PHASES = 2;
`else
    localparam int CLEAN_EDGE   = 65;
    localparam int CLEAN_PHASES = 1;
`endif

    typedef struct packed {
        logic [4:0] a;
        logic [7:0] d;
    } wr_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic       wr;
    logic       rd;
    logic [4:0] addr;
    wire  [7:0] data;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] fail_addr;
    logic [7:0] fail_data;

    int         checks_total;
    int         checks_passed;
    int         overlap_cnt;
    int         fault_mode;
    wr_t        exp_q[$];
    wr_t        mon_e;
    logic [7:0] mem [0:31];
    logic [7:0] rd_val;

    memory_bist #(
        .AWIDTH (5),
        .DWIDTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .wr        (wr),
        .rd        (rd),
        .addr      (addr),
        .data      (data),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_addr (fail_addr),
        .fail_data (fail_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: write on the clock, combinational read with faults.
    always @(posedge clk) begin
        if (wr === 1'b1) mem[addr] <= data;
    end

    always_comb begin
        rd_val = mem[addr];
        case (fault_mode)
            1: rd_val[0] = 1'b1;
            2: if (addr == 5'd3) rd_val = 8'hFF;
            3: rd_val[7] = 1'b0;
            default: ;
        endcase
    end

    assign data = rd ? rd_val : 8'hzz;

    function automatic logic [7:0] p_ref(input int a, input bit inv);
        logic [7:0] v;
        v = 8'(31 - a);
        return inv ? ~v : v;
    endfunction

    // Write monitor: every write cycle is checked against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (wr === 1'b1 && rd === 1'b1) overlap_cnt++;
            if (wr === 1'b1) begin
                checks_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_write addr=%h data=%h required=none", addr, data);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (addr !== mon_e.a || data !== mon_e.d)
                        $display("FAIL write addr=%h data=%h required addr=%h data=%h",
                                 addr, data, mon_e.a, mon_e.d);
                    else
                        checks_passed++;
                end
            end
        end
    end

    task automatic push_writes(input int phases);
        wr_t w;
        for (int ph = 0; ph < phases; ph++) begin
            for (int a = 31; a >= 0; a--) begin
                w.a = 5'(a);
                w.d = p_ref(a, ph == 1);
                exp_q.push_back(w);
            end
        end
    endtask

    // Launch one run and check its launch state, completion edge and result.
    task automatic run_bist(input string name, input int exp_edge, input logic exp_pass,
                            input logic [4:0] exp_fa, input logic [7:0] exp_fd,
                            input int phases);
        int k;
        exp_q.delete();
        push_writes(phases);
        overlap_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks_total++;
        if (busy !== 1'b1 || done !== 1'b0 || pass !== 1'b0 || wr !== 1'b1 || addr !== 5'h1F ||
            fail_addr !== 5'h00 || fail_data !== 8'h00)
            $display("FAIL %s_launch busy=%b done=%b pass=%b wr=%b addr=%h fa=%h fd=%h required 1 0 0 1 1f 00 00",
                     name, busy, done, pass, wr, addr, fail_addr, fail_data);
        else checks_passed++;
        k = 0;
        while (k < 400 && done !== 1'b1) begin
            @(posedge clk);
            #1;
            k++;
        end
        checks_total++;
        if (k !== exp_edge) $display("FAIL %s_done_edge got=E%0d required=E%0d", name, k, exp_edge);
        else checks_passed++;
        checks_total++;
        if (pass !== exp_pass) $display("FAIL %s_pass got=%b required=%b", name, pass, exp_pass);
        else checks_passed++;
        checks_total++;
        if (fail_addr !== exp_fa) $display("FAIL %s_fail_addr got=%h required=%h", name, fail_addr, exp_fa);
        else checks_passed++;
        checks_total++;
        if (fail_data !== exp_fd) $display("FAIL %s_fail_data got=%h required=%h", name, fail_data, exp_fd);
        else checks_passed++;
        checks_total++;
        if (busy !== 1'b0 || wr !== 1'b0 || rd !== 1'b0)
            $display("FAIL %s_idle_pins busy=%b wr=%b rd=%b required 0 0 0", name, busy, wr, rd);
        else checks_passed++;
        checks_total++;
        if (exp_q.size() != 0) $display("FAIL %s_writes_missing got=%0d required=0", name, exp_q.size());
        else checks_passed++;
        checks_total++;
        if (overlap_cnt != 0) $display("FAIL %s_wr_rd_overlap got=%0d required=0", name, overlap_cnt);
        else checks_passed++;
        $display("run %s: done_edge=E%0d pass=%0b fail_addr=%h fail_data=%h", name, k, pass, fail_addr, fail_data);
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks_total++;
        if (wr !== 1'b0 || rd !== 1'b0 || addr !== 5'h00 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0)
            $display("FAIL reset_ctrl wr=%b rd=%b addr=%h busy=%b done=%b pass=%b required all 0",
                     wr, rd, addr, busy, done, pass);
        else checks_passed++;
        checks_total++;
        if (fail_addr !== 5'h00 || fail_data !== 8'h00)
            $display("FAIL reset_fail_regs fa=%h fd=%h required 00 00", fail_addr, fail_data);
        else checks_passed++;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks_total++;
        if (busy !== 1'b0 || wr !== 1'b0)
            $display("FAIL reset_start_ignored busy=%b wr=%b required 0 0", busy, wr);
        else checks_passed++;
        $display("run reset: busy=%0b done=%0b", busy, done);
    endtask

    task automatic test_clean_run();
        fault_mode = 0;
        run_bist("clean", CLEAN_EDGE, 1'b1, 5'h00, 8'h00, CLEAN_PHASES);
    endtask

    task automatic test_stuck_bit0();
        fault_mode = 1;
        run_bist("stuck_bit0", 34, 1'b0, 5'h1F, 8'h01, 1);
    endtask

    task automatic test_fault_addr3();
        fault_mode = 2;
        run_bist("fault_addr3", 62, 1'b0, 5'h03, 8'hFF, 1);
    endtask

    task automatic test_start_in_done();
        repeat (3) @(posedge clk);
        #1;
        checks_total++;
        if (done !== 1'b1 || pass !== 1'b0)
            $display("FAIL done_held done=%b pass=%b required 1 0", done, pass);
        else checks_passed++;
        fault_mode = 0;
        run_bist("restart_from_done", CLEAN_EDGE, 1'b1, 5'h00, 8'h00, CLEAN_PHASES);
    endtask

    task automatic test_start_ignored_and_rst();
        fault_mode = 0;
        exp_q.delete();
        push_writes(1);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks_total++;
        if (addr !== 5'd21 || busy !== 1'b1 || wr !== 1'b1)
            $display("FAIL start_while_busy addr=%h busy=%b wr=%b required 15 1 1", addr, busy, wr);
        else checks_passed++;
        repeat (29) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks_total++;
        if (wr !== 1'b0 || rd !== 1'b0 || addr !== 5'h00 || busy !== 1'b0 || done !== 1'b0 ||
            pass !== 1'b0 || fail_addr !== 5'h00 || fail_data !== 8'h00)
            $display("FAIL mid_run_reset wr=%b rd=%b addr=%h busy=%b done=%b pass=%b fa=%h fd=%h required all 0",
                     wr, rd, addr, busy, done, pass, fail_addr, fail_data);
        else checks_passed++;
        checks_total++;
        if (exp_q.size() != 0) $display("FAIL aborted_run_writes got=%0d required=0", exp_q.size());
        else checks_passed++;
        $display("run abort_at_E40: busy=%0b done=%0b", busy, done);
        @(negedge clk);
        rst = 1'b0;
        run_bist("after_reset", CLEAN_EDGE, 1'b1, 5'h00, 8'h00, CLEAN_PHASES);
    endtask

`ifdef MEMORY_BIST_INVERT_PASS_EN
    task automatic test_invert_bit7();
        fault_mode = 3;
        run_bist("stuck_bit7", 100, 1'b0, 5'h1F, 8'h7F, 2);
    endtask
`endif

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        overlap_cnt   = 0;
        fault_mode    = 0;
        rst           = 1'b1;
        start         = 1'b0;
        test_reset();
        test_clean_run();
        test_stuck_bit0();
        test_fault_addr3();
        test_start_in_done();
        test_start_ignored_and_rst();
`ifdef MEMORY_BIST_INVERT_PASS_EN
        test_invert_bit7();
`endif
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
